// File: rtl/dekatron_pulse_sequencer.sv
// Dekatron guide-pulse sequencer: drives the two guide electrodes to step the
// glow one cathode up or down, verifies the landing from cathode feedback, and
// can run the glow back to position 0 by repeated increment steps.
module dekatron_pulse_sequencer #(
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned SETTLE_MAX = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Request,
  input  logic       Dec,
  input  logic       Zero,
  input  logic [9:0] In,
  output logic [1:0] Guide,
  output logic       Busy,
  output logic       Ready,
  output logic       Carry,
  output logic       Borrow,
  output logic [3:0] Position,
  output logic       Fault
);

  typedef enum logic [2:0] {
    IDLE,
    PH_A,
    PH_B,
    SETTLE,
    DONE,
    FAULT
  } state_t;

  localparam logic [7:0] PulseLen  = 8'(PULSE_LEN);
  localparam logic [7:0] SettleMax = 8'(SETTLE_MAX);

  state_t     state;
  logic [7:0] phaseCnt;
  logic [7:0] settleCnt;
  logic [3:0] target;
  logic [3:0] stepCnt;
  logic       dirDec;
  logic       zeroSeq;

  function automatic logic [3:0] encode(input logic [9:0] v);
    logic [3:0] r;
    r = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (v[k]) r = 4'(k);
    end
    return r;
  endfunction

  function automatic logic [9:0] decode(input logic [3:0] p);
    return 10'd1 << p;
  endfunction

  function automatic logic [3:0] incMod(input logic [3:0] p);
    return (p == 4'd9) ? 4'd0 : p + 4'd1;
  endfunction

  function automatic logic [3:0] decMod(input logic [3:0] p);
    return (p == 4'd0) ? 4'd9 : p - 4'd1;
  endfunction

  // Helper decodes of the feedback bus and the latched target
  logic       inOneHot;
  logic [3:0] inPos;
  logic       atTarget;
  logic       atZero;
  logic [1:0] guideB;

  // Combinational views of feedback and second-phase guide drive
  always_comb begin
    inOneHot = $onehot(In);
    inPos    = encode(In);
    atTarget = (In == decode(target));
    atZero   = (In == 10'd1);
    guideB   = dirDec ? 2'b01 : 2'b10;
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      phaseCnt  <= '0;
      settleCnt <= '0;
      target    <= '0;
      stepCnt   <= '0;
      dirDec    <= 1'b0;
      zeroSeq   <= 1'b0;
      Guide     <= '0;
      Busy      <= 1'b0;
      Ready     <= 1'b0;
      Carry     <= 1'b0;
      Borrow    <= 1'b0;
      Position  <= '0;
      Fault     <= 1'b0;
    end else begin
      Ready  <= 1'b0;
      Carry  <= 1'b0;
      Borrow <= 1'b0;
      case (state)
        IDLE: begin
          Guide <= '0;
          Busy  <= 1'b0;
          if (Zero) begin
            zeroSeq <= 1'b1;
            dirDec  <= 1'b0;
            stepCnt <= 4'd1;
            Busy    <= 1'b1;
            if (atZero) begin
              target   <= '0;
              Position <= '0;
              Ready    <= 1'b1;
              state    <= DONE;
            end else begin
              target   <= incMod(Position);
              phaseCnt <= 8'd1;
              Guide    <= 2'b01;
              state    <= PH_A;
            end
          end else if (Request) begin
            zeroSeq  <= 1'b0;
            dirDec   <= Dec;
            target   <= Dec ? decMod(Position) : incMod(Position);
            phaseCnt <= 8'd1;
            Guide    <= Dec ? 2'b10 : 2'b01;
            Busy     <= 1'b1;
            state    <= PH_A;
          end else if (inOneHot && (inPos != Position)) begin
            Position <= inPos;
          end
        end
        PH_A: begin
          if (phaseCnt == PulseLen) begin
            phaseCnt <= 8'd1;
            Guide    <= guideB;
            state    <= PH_B;
          end else begin
            phaseCnt <= phaseCnt + 8'd1;
          end
        end
        PH_B: begin
          if (phaseCnt == PulseLen) begin
            Guide     <= '0;
            settleCnt <= 8'd1;
            state     <= SETTLE;
          end else begin
            phaseCnt <= phaseCnt + 8'd1;
          end
        end
        SETTLE: begin
          if (atTarget) begin
            if (zeroSeq && (target != 4'd0)) begin
              // Intermediate zeroing step: chain straight into the next pulse
              if (stepCnt == 4'd9) begin
                Fault <= 1'b1;
                state <= FAULT;
              end else begin
                stepCnt  <= stepCnt + 4'd1;
                target   <= incMod(target);
                phaseCnt <= 8'd1;
                Guide    <= 2'b01;
                state    <= PH_A;
              end
            end else begin
              Ready    <= 1'b1;
              Carry    <= !zeroSeq && !dirDec && (target == 4'd0);
              Borrow   <= !zeroSeq && dirDec && (target == 4'd9);
              Position <= target;
              state    <= DONE;
            end
          end else if (!inOneHot || (settleCnt == SettleMax)) begin
            Fault <= 1'b1;
            state <= FAULT;
          end else begin
            settleCnt <= settleCnt + 8'd1;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          Fault <= 1'b1;
          Busy  <= 1'b1;
          Guide <= '0;
        end
        default: begin
          Guide <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
